// File: rtl/multi_channel_timer.sv
// multi_channel_timer: CHANNELS independent WIDTH-bit timers sharing one tick
// enable. Each channel latches a terminal value and a periodic/one-shot mode on
// start, counts enabled ticks from 0 to terminal, and emits a registered
// one-cycle done pulse on every rollover.

module multi_channel_timer_ch #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             tick_en,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] terminal,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  // State, count, latched configuration and done pulse registers.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      term_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Next state: stop beats start beats tick; done only on an enabled rollover.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (start && !stop) begin
          term_d  = terminal;
          mode_d  = oneshot;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          count_d = '0;
        end else if (start) begin
          // Restart: relatch and count again from zero, no pulse.
          term_d  = terminal;
          mode_d  = oneshot;
          count_d = '0;
        end else if (tick_en) begin
          if (count_q == term_q) begin
            count_d = '0;
            done_d  = 1'b1;
            if (mode_q) state_d = IDLE;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

module multi_channel_timer #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      tick_en,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       oneshot,
  input  logic [CHANNELS*WIDTH-1:0] terminal,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       done
);

  // One independent channel per lane; only tick_en is shared.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    multi_channel_timer_ch #(.WIDTH(WIDTH)) u_ch (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .tick_en  (tick_en),
      .start    (start[gi]),
      .stop     (stop[gi]),
      .oneshot  (oneshot[gi]),
      .terminal (terminal[gi*WIDTH +: WIDTH]),
      .count    (count[gi*WIDTH +: WIDTH]),
      .busy     (busy[gi]),
      .done     (done[gi])
    );
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Bench for multi_channel_timer: directed stimulus, an elapsed-tick reference
// model compared every cycle, plus hand-computed literal expectations.

module tb_multi_channel_timer;
  localparam int CH = 4;
  localparam int W  = 8;

  logic            sys_clk = 1'b0;
  logic            rst = 1'b1;
  logic            tick_en = 1'b0;
  logic [CH-1:0]   start = '0, stop = '0, oneshot = '0;
  logic [CH*W-1:0] terminal = '0;
  logic [CH*W-1:0] count;
  logic [CH-1:0]   busy, done;

  int checks = 0;
  int failures = 0;

  multi_channel_timer #(.CHANNELS(CH), .WIDTH(W)) dut (
    .sys_clk(sys_clk), .rst(rst), .tick_en(tick_en), .start(start),
    .stop(stop), .oneshot(oneshot), .terminal(terminal),
    .count(count), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: a channel is described by how many enabled ticks have
  // elapsed since its last start; count and done follow from modular arithmetic.
  bit m_run  [CH];
  int m_el   [CH];
  int m_term [CH];
  bit m_mode [CH];
  bit m_done [CH];

  always @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_run[c] <= 0; m_el[c] <= 0; m_term[c] <= 0; m_mode[c] <= 0; m_done[c] <= 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        int e;
        m_done[c] <= 0;
        if (start[c] && !stop[c]) begin
          m_run[c] <= 1; m_el[c] <= 0;
          m_term[c] <= int'(terminal[c*W +: W]); m_mode[c] <= oneshot[c];
        end else if (stop[c]) begin
          m_run[c] <= 0; m_el[c] <= 0;
        end else if (m_run[c] && tick_en) begin
          e = m_el[c] + 1;
          if (e % (m_term[c] + 1) == 0) begin
            m_done[c] <= 1;
            if (m_mode[c]) begin
              m_run[c] <= 0; e = 0;
            end
          end
          m_el[c] <= e;
        end
      end
    end
  end

  function automatic logic [CH*W-1:0] exp_count();
    logic [CH*W-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++)
      if (m_run[c]) v[c*W +: W] = W'(m_el[c] % (m_term[c] + 1));
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_busy();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_run[c];
    return v;
  endfunction

  function automatic logic [CH-1:0] exp_done();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_done[c];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge sys_clk) begin
    if (!rst) begin
      check("model_count", 64'(count), 64'(exp_count()));
      check("model_busy",  64'(busy),  64'(exp_busy()));
      check("model_done",  64'(done),  64'(exp_done()));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [CH-1:0] m);
    start = m;
    step(1);
    start = '0;
  endtask

  task automatic set_term(input int c, input int v);
    terminal[c*W +: W] = W'(v);
  endtask

  function automatic logic [W-1:0] cnt(input int c);
    return count[c*W +: W];
  endfunction

  initial begin
    #2;
    check("reset_count", 64'(count), 64'(0));
    check("reset_busy",  64'(busy),  64'(0));
    check("reset_done",  64'(done),  64'(0));
    #10 rst = 1'b0;
    step(2);

    // 1: ch0 periodic, terminal 8
    tick_en = 1'b1;
    set_term(0, 8); oneshot[0] = 1'b0;
    pulse_start(4'b0001);
    check("t1_busy0", 64'(busy[0]), 64'(1));
    check("t1_cnt0_start", 64'(cnt(0)), 64'(0));
    step(8);
    check("t1_cnt0_8", 64'(cnt(0)), 64'(8));
    check("t1_nodone", 64'(done[0]), 64'(0));
    step(1);
    check("t1_done_9th", 64'(done[0]), 64'(1));
    check("t1_wrap", 64'(cnt(0)), 64'(0));
    step(9);
    check("t1_done_18th", 64'(done[0]), 64'(1));
    step(1);
    check("t1_done_low", 64'(done[0]), 64'(0));

    // 2: ch1 one-shot, terminal 3
    set_term(1, 3); oneshot[1] = 1'b1;
    pulse_start(4'b0010);
    step(3);
    check("t2_cnt1_3", 64'(cnt(1)), 64'(3));
    check("t2_busy_pre", 64'(busy[1]), 64'(1));
    step(1);
    check("t2_done", 64'(done[1]), 64'(1));
    check("t2_busy_fall", 64'(busy[1]), 64'(0));
    check("t2_cnt1_0", 64'(cnt(1)), 64'(0));
    step(20);
    check("t2_still_idle", 64'(busy[1]), 64'(0));

    // 3: ch0 periodic, terminal 2, tick_en toggling
    stop = 4'b0001; step(1); stop = '0;
    set_term(0, 2);
    pulse_start(4'b0001);
    for (int i = 1; i <= 12; i++) begin
      tick_en = (i % 2 == 1);
      step(1);
      check("t3_done", 64'(done[0]), 64'((i == 5 || i == 11) ? 1 : 0));
    end
    tick_en = 1'b1;

    // 4: ch2 stop+start at count 5, then restart sequence
    set_term(2, 9); oneshot[2] = 1'b0;
    pulse_start(4'b0100);
    step(5);
    check("t4_cnt2_5", 64'(cnt(2)), 64'(5));
    start = 4'b0100; stop = 4'b0100;
    step(1);
    start = '0; stop = '0;
    check("t4_stop_busy", 64'(busy[2]), 64'(0));
    check("t4_stop_cnt", 64'(cnt(2)), 64'(0));
    check("t4_stop_done", 64'(done[2]), 64'(0));
    step(2);
    set_term(2, 4);
    pulse_start(4'b0100);
    step(2);
    check("t4_cnt2_2", 64'(cnt(2)), 64'(2));
    set_term(2, 1);
    pulse_start(4'b0100);
    check("t4_restart_cnt", 64'(cnt(2)), 64'(0));
    check("t4_restart_nodone", 64'(done[2]), 64'(0));
    step(1);
    check("t4_cnt2_1", 64'(cnt(2)), 64'(1));
    step(1);
    check("t4_done", 64'(done[2]), 64'(1));

    // 5a: ch3 periodic, terminal 0 -> done every cycle
    set_term(3, 0); oneshot[3] = 1'b0;
    pulse_start(4'b1000);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t5_term0_done", 64'(done[3]), 64'(1));
    end
    stop = 4'b1000; step(1); stop = '0;
    check("t5_term0_stopped", 64'(done[3]), 64'(0));

    // 5b: ch0 full range; terminal changes mid-run are ignored
    set_term(0, 255);
    pulse_start(4'b0001);
    set_term(0, 5);
    step(255);
    check("t5_cnt255", 64'(cnt(0)), 64'(255));
    check("t5_nodone255", 64'(done[0]), 64'(0));
    step(1);
    check("t5_full_done", 64'(done[0]), 64'(1));
    check("t5_full_wrap", 64'(cnt(0)), 64'(0));
    step(1);
    check("t5_full_single", 64'(done[0]), 64'(0));

    // 6: async reset mid-run
    set_term(1, 7); oneshot[1] = 1'b0;
    set_term(3, 3);
    pulse_start(4'b1010);
    step(3);
    @(posedge sys_clk);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_count", 64'(count), 64'(0));
    check("t6_rst_busy",  64'(busy),  64'(0));
    check("t6_rst_done",  64'(done),  64'(0));
    #10 rst = 1'b0;
    step(5);
    check("t6_idle_busy",  64'(busy),  64'(0));
    check("t6_idle_count", 64'(count), 64'(0));

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/multi_channel_timer.md
Name: multi_channel_timer

Overview:
- Parametrised successor to the single fixed-terminal wrap counter.
- Provides CHANNELS independent counters of WIDTH bits, each with:
  - a terminal value loaded at runtime,
  - periodic or one-shot mode,
  - start/stop control,
  - a registered one-cycle done pulse.
- A shared tick enable acts as a prescaler hook.
- Sits between control logic and any block that needs timeouts or periodic strobes.

Parameters:
- CHANNELS, 4, number of independent timer channels (>=1).
- WIDTH, 8, counter and terminal width in bits (>=1).

Ports:
- sys_clk  input  1  system clock, rising-edge.
- rst  input  1  reset rst, asynchronous, active-high; clock sys_clk.
- tick_en  input  1  shared count enable; counters advance only when high.
- start  input  CHANNELS  per-channel start/restart request, sampled each edge.
- stop  input  CHANNELS  per-channel stop request; priority over start.
- oneshot  input  CHANNELS  per-channel mode, latched on start (1 = one-shot, 0 = periodic).
- terminal  input  CHANNELS*WIDTH  per-channel terminal value, latched on start; channel i = bits [i*WIDTH +: WIDTH].
- count  output  CHANNELS*WIDTH  current count per channel, registered, same packing as terminal.
- busy  output  CHANNELS  channel in RUN state, registered.
- done  output  CHANNELS  one-cycle registered pulse at terminal rollover.

Behaviour:
- Reset (async, any time, including mid-run): all channels go to IDLE; count=0, busy=0, done=0, latched terminal=0, latched mode=0.
- Channels are fully independent; the only shared input is tick_en.

Per-channel states are IDLE and RUN.
- IDLE:
  - count=0, busy=0.
  - start=1 and stop=0: latch terminal and oneshot, count<=0, go to RUN (busy=1 from the next cycle).
  - Otherwise remain in IDLE.
- RUN, evaluated per edge in this priority order:
  1. stop=1: go to IDLE, count<=0, done<=0. No done pulse, even if at terminal.
  2. start=1: relatch terminal and mode, count<=0, stay in RUN, done<=0 (restart suppresses done).
  3. tick_en=0: hold count, done<=0.
  4. tick_en=1 and count != latched terminal: count<=count+1, done<=0.
  5. tick_en=1 and count == latched terminal: count<=0, done<=1. Periodic stays in RUN; one-shot goes to IDLE (busy falls on the same edge done rises).

Period and latency:
- Period is (terminal+1) enabled ticks.
- With tick_en held high, the first done occurs terminal+1 edges after the start edge.
- Terminal=0, periodic, tick_en high: done is high every cycle while running.
- Terminal=0, one-shot: done on the first enabled edge after start.

Arithmetic and interface rules:
- Count compares equal against the latched terminal only and never exceeds it.
- Terminal = 2^WIDTH-1 counts the full range and returns to 0 with no overflow artefacts.
- Changes on terminal/oneshot inputs while in RUN have no effect until the next start.
- done is strictly one cycle per rollover and is never asserted in IDLE.
- start/stop are level-sampled per edge: holding start high in RUN restarts every cycle (no progress). Callers pulse start.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. CHANNELS=4, WIDTH=8. ch0 periodic, terminal=8, tick_en=1, start pulse -> count 0,1,...,8,0,...; done pulses every 9 cycles, first on the 9th edge after start; busy stays 1.
2. ch1 one-shot, terminal=3 -> done pulses once on the 4th edge after start; busy falls on the same edge; count=0; no further done over 20 cycles.
3. ch0 periodic, terminal=2, tick_en toggling 1,0,1,0,... -> done every 6 cycles; count holds during tick_en=0 cycles.
4. ch2 running at count=5:
   - start+stop in the same cycle -> IDLE, busy=0, count=0, no done.
   - Later, start with terminal=4, then start again at count=2 with terminal=1 -> count restarts at 0; done at 2 enabled edges after the second start; no done at the restart.
5. Edge cases:
   - ch3 periodic, terminal=0 -> done continuously high while running.
   - ch0 terminal=255 -> count reaches 255 then 0 with a single done.
   - Other channels remain unaffected throughout.
6. Assert rst for 1 cycle mid-run on all channels (asynchronous, between edges) -> all count/busy/done go 0 immediately; after release, channels stay IDLE until a new start.
